// File: rtl/regfile_piso.sv
// -----------------------------------------------------------------------------
// regfile_piso -- parallel-in, serial-out register file (RegSize x DataSize)
//
// Write side: one strobe stores three consecutive registers
//   REG[a], REG[a+1], REG[a+2]. Addresses wrap modulo RegSize.
// Read side: a two-state burst engine (IDLE/STREAM) streams rd_len+1
//   consecutive registers out through a registered dout, one word per
//   clock, with dout_valid/dout_last flags. busy mirrors dout_valid.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   reg_enable   global enable; low stalls writes and the read engine
//   reg_write    triple-write strobe
//   write_addr   base write address
//   write_data1  data for REG[write_addr]
//   write_data2  data for REG[write_addr+1]
//   write_data3  data for REG[write_addr+2]
//   rd_start     burst request (sampled only in IDLE)
//   rd_addr      burst start address
//   rd_len       burst length minus one
//   busy         burst in progress
//   dout         serial read data (registered)
//   dout_valid   dout holds a burst word
//   dout_last    dout is the final word of the burst
//
// Optional feature (macro WRITE_BYPASS_EN):
//   defined   -> a word loaded into dout on the same edge that writes its
//                address takes the new write data (write-first).
//   undefined -> dout takes the old register contents (read-first).
// -----------------------------------------------------------------------------
module regfile_piso #(
   parameter int AddrSize = 7,
   parameter int DataSize = 32,
   parameter int RegSize  = 128,
   parameter int LenSize  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reg_enable,
   input  logic                reg_write,
   input  logic [AddrSize-1:0] write_addr,
   input  logic [DataSize-1:0] write_data1,
   input  logic [DataSize-1:0] write_data2,
   input  logic [DataSize-1:0] write_data3,
   input  logic                rd_start,
   input  logic [AddrSize-1:0] rd_addr,
   input  logic [LenSize-1:0]  rd_len,
   output logic                busy,
   output logic [DataSize-1:0] dout,
   output logic                dout_valid,
   output logic                dout_last
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t              state_reg, state_next;
   logic [DataSize-1:0] reg_file [RegSize];
   logic [AddrSize-1:0] ptr_reg, ptr_next;
   logic [LenSize-1:0]  cnt_reg, cnt_next;
   logic [DataSize-1:0] dout_reg, dout_next;
   logic                valid_reg, valid_next;
   logic                last_reg, last_next;

   logic                wr_en;
   logic [AddrSize-1:0] wr_port_addr [3];
   logic [DataSize-1:0] wr_port_data [3];
   logic [AddrSize-1:0] rd_sel;
   logic [DataSize-1:0] rd_word;

   assign wr_en           = reg_enable & reg_write;
   assign wr_port_data[0] = write_data1;
   assign wr_port_data[1] = write_data2;
   assign wr_port_data[2] = write_data3;

   // The three write ports sit at a, a+1, a+2; the natural AddrSize-bit
   // overflow gives the modulo-RegSize wrap.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_wr_port
         assign wr_port_addr[gi] = write_addr + AddrSize'(gi);
      end
   endgenerate

   // ---------------- storage ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RegSize; i++) begin
            reg_file[i] <= '0;
         end
      end else if (wr_en) begin
         for (int p = 0; p < 3; p++) begin
            reg_file[wr_port_addr[p]] <= wr_port_data[p];
         end
      end
   end

   // ---------------- read word selection ----------------
   // In IDLE the first word comes straight from rd_addr so it appears one
   // clock after rd_start; in STREAM the running pointer is used.
   assign rd_sel = (state_reg == IDLE) ? rd_addr : ptr_reg;

`ifdef WRITE_BYPASS_EN
   logic [2:0] byp_hit;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_byp
         assign byp_hit[gi] = wr_en && (rd_sel == wr_port_addr[gi]);
      end
   endgenerate

   // At most one port can hit: the three write addresses are distinct.
   always_comb begin
      rd_word = reg_file[rd_sel];
      for (int p = 0; p < 3; p++) begin
         if (byp_hit[p]) begin
            rd_word = wr_port_data[p];
         end
      end
   end
`else
   assign rd_word = reg_file[rd_sel];
`endif

   // ---------------- burst engine ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         dout_reg  <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         dout_reg  <= dout_next;
         valid_reg <= valid_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      dout_next  = dout_reg;
      valid_next = valid_reg;
      last_next  = last_reg;

      if (reg_enable) begin
         case (state_reg)
            IDLE: begin
               if (rd_start) begin
                  state_next = STREAM;
                  ptr_next   = rd_addr + AddrSize'(1);
                  cnt_next   = rd_len;
                  dout_next  = rd_word;
                  valid_next = 1'b1;
                  last_next  = (rd_len == '0);
               end
            end
            STREAM: begin
               if (last_reg) begin
                  // dout keeps the final word; only the flags drop.
                  state_next = IDLE;
                  valid_next = 1'b0;
                  last_next  = 1'b0;
               end else begin
                  dout_next = rd_word;
                  ptr_next  = ptr_reg + AddrSize'(1);
                  cnt_next  = cnt_reg - LenSize'(1);
                  // cnt counts words still to load; 1 means this is the last.
                  last_next = (cnt_reg == LenSize'(1));
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = valid_reg;
   assign dout_last  = last_reg;
   assign busy       = valid_reg;

endmodule

// File: tb/tb_regfile_piso.sv
// -----------------------------------------------------------------------------
// tb_regfile_piso -- self-checking bench for regfile_piso.
// Keeps a plain array image of the register file and derives every streamed
// word as mem[(rd_addr + k) mod 128]. Table-driven write/burst vectors,
// hand-written collision, stall, ignored-start and reset sequences, then
// randomized writes and bursts.
// -----------------------------------------------------------------------------
module tb_regfile_piso;

   logic        clk;
   logic        rst;
   logic        reg_enable;
   logic        reg_write;
   logic [6:0]  write_addr;
   logic [31:0] write_data1, write_data2, write_data3;
   logic        rd_start;
   logic [6:0]  rd_addr;
   logic [2:0]  rd_len;
   logic        busy;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_last;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [128];

   typedef struct {
      logic [6:0]  wa;
      logic [31:0] d1, d2, d3;
      logic [6:0]  ra;
      logic [2:0]  len;
      int          stall_at;
      int          pulse_at;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   localparam int NV = 6;
   vec_t vt [NV];

   regfile_piso dut (
      .clk         (clk),
      .rst         (rst),
      .reg_enable  (reg_enable),
      .reg_write   (reg_write),
      .write_addr  (write_addr),
      .write_data1 (write_data1),
      .write_data2 (write_data2),
      .write_data3 (write_data3),
      .rd_start    (rd_start),
      .rd_addr     (rd_addr),
      .rd_len      (rd_len),
      .busy        (busy),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_last   (dout_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_write(input logic [6:0] wa, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
      logic [6:0] a;
      a = wa;        mem[a] = d1;
      a = a + 7'd1;  mem[a] = d2;
      a = a + 7'd1;  mem[a] = d3;
   endtask

   task automatic do_write(input logic [6:0] wa, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
      write_addr = wa; write_data1 = d1; write_data2 = d2; write_data3 = d3;
      reg_write = 1'b1;
      tick();
      reg_write = 1'b0;
      model_write(wa, d1, d2, d3);
      $display("write a=%0d d=%h %h %h", wa, d1, d2, d3);
   endtask

   // Runs one burst, checking every word against the model image.
   task automatic run_burst(input logic [6:0] ra, input logic [2:0] len,
                            input int stall_at, input int pulse_at,
                            output logic [31:0] first_w, output logic [31:0] last_w,
                            output int nwords);
      int          k;
      bit          done;
      logic [6:0]  ad;
      logic [31:0] held;
      logic        held_last;
      k = 0; done = 0; first_w = '0; last_w = '0;
      rd_addr = ra; rd_len = len; rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (!dout_valid) begin
            check("burst valid dropped early", 32'(dout_valid), 32'd1);
            done = 1;
         end else begin
            ad = ra + 7'(k);
            check("burst word", dout, mem[ad]);
            check("burst last flag", 32'(dout_last), 32'(k == int'(len)));
            check("busy==valid", 32'(busy), 32'(dout_valid));
            if (k == 0) first_w = dout;
            last_w = dout;
            if (k == stall_at) begin
               held = dout; held_last = dout_last;
               reg_enable = 1'b0;
               repeat (3) begin
                  tick();
                  check("stall dout", dout, held);
                  check("stall valid", 32'(dout_valid), 32'd1);
                  check("stall last", 32'(dout_last), 32'(held_last));
                  check("stall busy", 32'(busy), 32'd1);
               end
               reg_enable = 1'b1;
            end
            if (k == pulse_at) begin
               rd_start = 1'b1;
               rd_addr  = ra + 7'd64;
            end
            k++;
            if (dout_last) done = 1;
            tick();
            rd_start = 1'b0;
         end
      end
      if (!done) check("burst timeout", 32'd0, 32'd1);
      nwords = k;
      check("post-burst valid", 32'(dout_valid), 32'd0);
      check("post-burst busy", 32'(busy), 32'd0);
      check("post-burst last", 32'(dout_last), 32'd0);
      check("post-burst dout hold", dout, last_w);
      $display("burst ra=%0d len=%0d words=%0d last=%h", ra, len, nwords, last_w);
   endtask

   logic [31:0] fw, lw, exp_w;
   int          nw;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      vt[0] = '{7'd126, 32'hffff_0000, 32'hffff_0001, 32'hffff_0002, 7'd126, 3'd2, -1, -1, 32'hffff_0000, 32'hffff_0002};
      vt[1] = '{7'd20,  32'h0000_000a, 32'h0000_000b, 32'h0000_000c, 7'd20,  3'd0, -1, -1, 32'h0000_000a, 32'h0000_000a};
      vt[2] = '{7'd127, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 7'd0,   3'd0, -1, -1, 32'h0000_0022, 32'h0000_0022};
      vt[3] = '{7'd40,  32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 7'd39,  3'd3,  1, -1, 32'h0000_0000, 32'h0000_0102};
      vt[4] = '{7'd3,   32'h0000_0003, 32'h0000_0004, 32'h0000_0005, 7'd5,   3'd0, -1, -1, 32'h0000_0005, 32'h0000_0005};
      vt[5] = '{7'd50,  32'h0000_0007, 32'h0000_0008, 32'h0000_0009, 7'd50,  3'd3, -1,  2, 32'h0000_0007, 32'h0000_0000};

      rst = 1'b0; reg_enable = 1'b1; reg_write = 1'b0; write_addr = '0;
      write_data1 = '0; write_data2 = '0; write_data3 = '0;
      rd_start = 1'b0; rd_addr = '0; rd_len = '0;
      #12 rst = 1'b1;
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset dout", dout, 32'd0);
      check("reset valid", 32'(dout_valid), 32'd0);
      check("reset last", 32'(dout_last), 32'd0);
      tick();
      run_burst(7'd60, 3'd7, -1, -1, fw, lw, nw);
      check("reset burst words", 32'(nw), 32'd8);

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         do_write(vt[i].wa, vt[i].d1, vt[i].d2, vt[i].d3);
         run_burst(vt[i].ra, vt[i].len, vt[i].stall_at, vt[i].pulse_at, fw, lw, nw);
         check("vec first word", fw, vt[i].exp_first);
         check("vec last word", lw, vt[i].exp_last);
         check("vec word count", 32'(nw), 32'(int'(vt[i].len) + 1));
         tick();
         check("vec no second burst", 32'(dout_valid), 32'd0);
      end

      // Write blocked while disabled.
      reg_enable = 1'b0;
      write_addr = 7'd70; write_data1 = 32'hdead_0001;
      write_data2 = 32'hdead_0002; write_data3 = 32'hdead_0003;
      reg_write = 1'b1;
      tick();
      reg_write = 1'b0; reg_enable = 1'b1;
      run_burst(7'd70, 3'd2, -1, -1, fw, lw, nw);
      check("disabled write ignored", lw, 32'd0);

      // Collision on the first port (streaming word 2 of a burst).
      do_write(7'd9, 32'haaaa_0009, 32'haaaa_0010, 32'haaaa_0011);
      rd_addr = 7'd9; rd_len = 3'd1; rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("coll1 first", dout, 32'haaaa_0009);
      write_addr = 7'd10; write_data1 = 32'h1234_5678;
      write_data2 = 32'h2222_0011; write_data3 = 32'h3333_0012;
      reg_write = 1'b1;
      tick();
      reg_write = 1'b0;
`ifdef WRITE_BYPASS_EN
      exp_w = 32'h1234_5678;
`else
      exp_w = 32'haaaa_0010;
`endif
      check("coll1 dout", dout, exp_w);
      check("coll1 last", 32'(dout_last), 32'd1);
      model_write(7'd10, 32'h1234_5678, 32'h2222_0011, 32'h3333_0012);
      tick();
      check("coll1 idle", 32'(dout_valid), 32'd0);

      // Collision on the third port, on the IDLE->STREAM edge.
      rd_addr = 7'd12; rd_len = 3'd0; rd_start = 1'b1;
      write_addr = 7'd10; write_data1 = 32'h5555_0010;
      write_data2 = 32'h5555_0011; write_data3 = 32'h5555_aaaa;
      reg_write = 1'b1;
      tick();
      rd_start = 1'b0; reg_write = 1'b0;
`ifdef WRITE_BYPASS_EN
      exp_w = 32'h5555_aaaa;
`else
      exp_w = 32'h3333_0012;
`endif
      check("coll2 dout", dout, exp_w);
      check("coll2 last", 32'(dout_last), 32'd1);
      model_write(7'd10, 32'h5555_0010, 32'h5555_0011, 32'h5555_aaaa);
      tick();
      check("coll2 idle", 32'(dout_valid), 32'd0);
      run_burst(7'd10, 3'd2, -1, -1, fw, lw, nw);
      check("coll new value visible", lw, 32'h5555_aaaa);

      // Randomized writes and bursts.
      for (int it = 0; it < 30; it++) begin
         logic [6:0] wa, ra;
         logic [2:0] ln;
         int         st;
         wa = 7'($urandom_range(0, 127));
         do_write(wa, $urandom, $urandom, $urandom);
         if (it % 2 == 0) begin
            ra = wa + 7'($urandom_range(0, 4)) - 7'd2;
            ln = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(ln))) : -1;
            run_burst(ra, ln, st, -1, fw, lw, nw);
            check("rand word count", 32'(nw), 32'(int'(ln) + 1));
         end
      end

      // Reset asserted mid-burst.
      rd_addr = 7'd126; rd_len = 3'd7; rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      tick();
      #2 rst = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst dout", dout, 32'd0);
      check("midrst valid", 32'(dout_valid), 32'd0);
      check("midrst last", 32'(dout_last), 32'd0);
      #1 rst = 1'b1;
      for (int i = 0; i < 128; i++) mem[i] = '0;
      tick();
      run_burst(7'd126, 3'd4, -1, -1, fw, lw, nw);
      check("midrst regs cleared", fw | lw, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
